chunked_mem: RTL
================

# chunked_mem

Parametrised successor to the two-cycle chunked-write data memory. A single shared command/bus interface carries addresses and write chunks: an address phase arms a write pointer, then one or more chunk phases fill sub-word fields, with optional auto-increment for burst stores. After reset the array is zeroed by a hardware sweep rather than an asynchronous clear, and reads are registered. Sits between the processor's load/store unit and the test harness dump logic.

## Interface
- WORD_W, 12, memory word width; must equal CHUNK_W*NCHUNK
- CHUNK_W, 6, bits written per chunk phase
- NCHUNK, 2, chunks per word (≥2)
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W
- BUS_W, 10, shared bus width; must be ≥ ADDR_W and ≥ CHUNK_W+$clog2(NCHUNK)
- AUTO_INC, 1, when 1 the write pointer increments after the last chunk is written
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- cmd  input  2  command (mem_cmd_t): NOP, SET_ADDR, WR_CHUNK, READ
- bus  input  BUS_W  address (SET_ADDR, READ: bus[ADDR_W-1:0]) or chunk (WR_CHUNK: data bus[CHUNK_W-1:0], index bus[CHUNK_W +: $clog2(NCHUNK)])
- rd_data  output  WORD_W  registered read data
- rd_valid  output  1  one-cycle pulse qualifying rd_data
- busy  output  1  high while clear sweep runs
- err  output  1  one-cycle pulse on illegal command
- wr_ptr  output  ADDR_W  current write pointer

## Operation
- States: CLEAR, IDLE (no pointer armed), ARMED.
- Reset: state=CLEAR, sweep counter=0, wr_ptr=0, rd_data=0, rd_valid=0, err=0, busy=1.
- CLEAR: writes 0 to address = sweep counter each cycle; after writing DEPTH-1 moves to IDLE, busy falls. Any non-NOP cmd during CLEAR: ignored, err pulses.
- SET_ADDR (IDLE or ARMED): wr_ptr <= bus[ADDR_W-1:0], state ARMED.
- WR_CHUNK in ARMED: mem[wr_ptr][idx*CHUNK_W +: CHUNK_W] <= data; other chunks unchanged. If idx == NCHUNK-1 and AUTO_INC: wr_ptr <= wr_ptr+1, wrapping DEPTH-1 → 0, stays ARMED. AUTO_INC=0: pointer holds.
- WR_CHUNK in IDLE: no write, err pulses. idx ≥ NCHUNK (non-power-of-2 NCHUNK): no write, err pulses, pointer unchanged.
- READ (IDLE or ARMED): rd_data <= mem[bus[ADDR_W-1:0]], rd_valid pulses next cycle; state and wr_ptr unchanged.
- NOP: rd_valid and err fall; rd_data holds last value.
- Reset asserted mid-burst or mid-sweep: returns to CLEAR and sweeps again; partial writes are discarded by the sweep.

## Timing
- Write: chunk visible to a READ issued the cycle after the WR_CHUNK.
- Read latency: 1 cycle, cmd=READ at edge N → rd_valid=1 and rd_data valid after edge N+1; back-to-back READs give back-to-back rd_valid.
- Clear sweep: DEPTH cycles after reset release; busy deasserts at the edge that writes address DEPTH-1.
- err: single-cycle pulse in the cycle after the offending command.
- Single command per cycle, so read/write collisions are impossible by construction.

## Structure
- Package common_def: mem_cmd_t enum (NOP=0, SET_ADDR=1, WR_CHUNK=2, READ=3), mem_state_t (CLEAR, IDLE, ARMED).
- Sub-module chunked_mem_array: synchronous single-port array with per-chunk write enable (NCHUNK bits), write data, address and registered read. It has no reset on storage and infers block RAM.
- Top level holds the FSM, sweep counter, pointer logic and err/rd_valid generation.
- Simulation-only $writememh dump kept out of this block.

## Test plan
- Reset, then run DEPTH cycles of NOP -> busy high for exactly 1024 cycles; READ 0x3FF -> rd_data=0x000, rd_valid one cycle later.
- SET_ADDR 0x005, WR_CHUNK idx0 data 0x2A, WR_CHUNK idx1 data 0x15, READ 0x005 -> rd_data=0x56A; wr_ptr=0x006 (AUTO_INC=1).
- SET_ADDR 0x3FF, write both chunks, then write idx0 data 0x01 -> mem[0x3FF] updated, wr_ptr wraps to 0x000, mem[0x000]=0x001.
- WR_CHUNK after reset sweep without SET_ADDR -> err pulse, READ 0x000 still 0x000; READ during CLEAR -> err, no rd_valid.
- Partial update: SET_ADDR 0x010, write idx1 only data 0x3F -> READ 0x010 = 0xFC0, wr_ptr increments to 0x011.
- Assert rst mid-burst after writing 0x123 at 0x020 -> busy returns high, after sweep READ 0x020 = 0x000.

Source files
------------

// File: rtl/chunked_mem_pkg.sv
// Shared command and state encodings for the chunked-write data memory.
package common_def;

   // Command carried on the shared cmd/bus interface, one per cycle.
   typedef enum logic [1:0] {
      NOP      = 2'd0,
      SET_ADDR = 2'd1,
      WR_CHUNK = 2'd2,
      READ     = 2'd3
   } mem_cmd_t;

   // CLEAR: post-reset zero sweep; IDLE: no write pointer armed;
   // ARMED: SET_ADDR seen, chunk writes go to wr_ptr.
   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      ARMED = 2'd2
   } mem_state_t;

   // Per-chunk write enable for a single chunk index.
   function automatic logic [31:0] chunk_onehot(input logic [31:0] idx);
      chunk_onehot = 32'd1 << idx;
   endfunction

endpackage

// File: rtl/chunked_mem_array.sv
// Single-port storage with per-chunk write enables and a registered read.
// Storage carries no reset so it maps onto block RAM; only the read
// register is reset so rd_data comes up as zero.
module chunked_mem_array #(
   parameter int WORD_W  = 12,
   parameter int CHUNK_W = 6,
   parameter int NCHUNK  = 2,
   parameter int ADDR_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [NCHUNK-1:0] we,
   input  logic [WORD_W-1:0] wdata,
   input  logic              re,
   output logic [WORD_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [WORD_W-1:0] mem [DEPTH];

   // Chunk-granular write: only enabled fields of the addressed word change.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NCHUNK; c++) begin
         if (we[c]) mem[addr][c*CHUNK_W +: CHUNK_W] <= wdata[c*CHUNK_W +: CHUNK_W];
      end
   end

   // Registered read; holds its last value when no read is issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/chunked_mem.sv
// Chunked-write data memory: an address phase arms a write pointer, chunk
// phases fill sub-word fields (optionally auto-incrementing after the last
// chunk), and reads are registered. After reset a hardware sweep zeroes the
// whole array before any command is accepted.
module chunked_mem
   import common_def::*;
#(
   parameter int WORD_W   = 12,
   parameter int CHUNK_W  = 6,
   parameter int NCHUNK   = 2,
   parameter int ADDR_W   = 10,
   parameter int BUS_W    = 10,
   parameter int AUTO_INC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  mem_cmd_t          cmd,
   input  logic [BUS_W-1:0]  bus,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              err,
   output logic [ADDR_W-1:0] wr_ptr
);

   localparam int IDX_W = $clog2(NCHUNK);

   // Parameter sanity, caught at elaboration.
   if (WORD_W != CHUNK_W * NCHUNK) begin : g_bad_word
      $error("chunked_mem: WORD_W must equal CHUNK_W*NCHUNK");
   end
   if (NCHUNK < 2) begin : g_bad_nchunk
      $error("chunked_mem: NCHUNK must be at least 2");
   end
   if (BUS_W < ADDR_W || BUS_W < CHUNK_W + IDX_W) begin : g_bad_bus
      $error("chunked_mem: BUS_W too narrow for address or chunk");
   end

   mem_state_t        state;
   logic [ADDR_W-1:0] sweep_cnt;

   // Bus fields for the two command formats.
   logic [ADDR_W-1:0]  bus_addr;
   logic [CHUNK_W-1:0] chunk_data;
   logic [IDX_W-1:0]   chunk_idx;
   logic [31:0]        idx_ext;
   logic               idx_ok;
   logic               idx_last;

   assign bus_addr   = bus[ADDR_W-1:0];
   assign chunk_data = bus[CHUNK_W-1:0];
   assign chunk_idx  = bus[CHUNK_W +: IDX_W];
   assign idx_ext    = 32'(chunk_idx);
   // Only reachable as false when NCHUNK is not a power of two.
   assign idx_ok     = idx_ext < 32'(NCHUNK);
   assign idx_last   = idx_ext == 32'(NCHUNK - 1);

   // Array port controls.
   logic [ADDR_W-1:0] mem_addr;
   logic [NCHUNK-1:0] mem_we;
   logic [WORD_W-1:0] mem_wdata;
   logic              mem_re;
   logic [31:0]       we_onehot;

   assign we_onehot = chunk_onehot(idx_ext);

   // Steer the single array port: sweep during CLEAR, otherwise the command.
   always_comb begin
      mem_addr  = wr_ptr;
      mem_we    = '0;
      mem_wdata = {NCHUNK{chunk_data}};
      mem_re    = 1'b0;
      if (state == CLEAR) begin
         mem_addr  = sweep_cnt;
         mem_we    = '1;
         mem_wdata = '0;
      end else begin
         if (cmd == READ) begin
            mem_re   = 1'b1;
            mem_addr = bus_addr;
         end else if (cmd == WR_CHUNK && state == ARMED && idx_ok) begin
            mem_we = we_onehot[NCHUNK-1:0];
         end
      end
   end

   chunked_mem_array #(
      .WORD_W  (WORD_W),
      .CHUNK_W (CHUNK_W),
      .NCHUNK  (NCHUNK),
      .ADDR_W  (ADDR_W)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .addr  (mem_addr),
      .we    (mem_we),
      .wdata (mem_wdata),
      .re    (mem_re),
      .rdata (rd_data)
   );

   // Control FSM: sweep, pointer arming/increment, err and rd_valid pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= CLEAR;
         sweep_cnt <= '0;
         wr_ptr    <= '0;
         rd_valid  <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b1;
      end else begin
         rd_valid <= 1'b0;
         err      <= 1'b0;
         case (state)
            CLEAR: begin
               sweep_cnt <= sweep_cnt + ADDR_W'(1);
               if (cmd != NOP) err <= 1'b1;
               // busy drops on the same edge that writes the last word
               if (&sweep_cnt) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            IDLE, ARMED: begin
               case (cmd)
                  SET_ADDR: begin
                     wr_ptr <= bus_addr;
                     state  <= ARMED;
                  end
                  WR_CHUNK: begin
                     if (state != ARMED || !idx_ok) err <= 1'b1;
                     else if (idx_last && AUTO_INC != 0) wr_ptr <= wr_ptr + ADDR_W'(1);
                  end
                  READ:    rd_valid <= 1'b1;
                  default: ;
               endcase
            end
            default: state <= CLEAR;
         endcase
      end
   end

endmodule
